stream_mux: RTL and testbench
=============================

Name: stream_mux

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer with a valid/ready handshake on every input and on the output.
- Next generation of the team's combinational 2:1 mux. Adds packet-aware channel locking, a selectable arbitration mode (explicit select or round-robin) and a registered output stage.
- Sits between multiple producer streams and a single consumer.

Parameters:
- NUM_CH, 4, number of input channels (must be >= 2).
- WIDTH, 8, data width per channel in bits.
- CH_W, $clog2(NUM_CH), localparam: width of channel index fields.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  arbitration mode: 0 = SELECT, 1 = ROUND_ROBIN.
- sel  in  CH_W  channel index used in SELECT mode.
- in_valid  in  NUM_CH  per-channel beat valid.
- in_data  in  NUM_CH*WIDTH  packed per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  NUM_CH  per-channel end-of-packet flag.
- in_ready  out  NUM_CH  per-channel ready (combinational).
- out_valid  out  1  registered output valid.
- out_data  out  WIDTH  registered output data.
- out_last  out  1  registered end-of-packet.
- out_ch  out  CH_W  source channel of the current output beat.
- out_ready  in  1  consumer ready.
- busy  out  1  high while a packet is locked (state LOCKED).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0. in_ready is all zeros while in reset.
- Handshake rules:
  - A beat transfers on an edge where valid && ready are both high.
  - Output register load enable: load = !out_valid || out_ready.
  - in_valid must not depend on in_ready.
  - in_ready depends combinationally on in_valid, mode, sel, state and out_ready; no combinational path to out_*.
- Candidate channel (evaluated in IDLE only):
  - SELECT mode: candidate = sel if sel < NUM_CH and in_valid[sel]; otherwise none.
  - ROUND_ROBIN mode: candidate = first i with in_valid[i] set, searching from rr_ptr upward modulo NUM_CH; none if in_valid == 0.
- Active channel: candidate in IDLE, grant in LOCKED.
- in_ready[i] = load && (i == active channel); at most one bit is set.
- State machine:
  - IDLE: if candidate exists and load, transfer the beat. If in_last = 0, go to LOCKED with grant = candidate. If in_last = 1 (single-beat packet), stay IDLE.
  - LOCKED: only the grant channel is served. On a transfer with in_last = 1, go to IDLE.
  - mode and sel are ignored while LOCKED; changes take effect at the next IDLE cycle.
- rr_ptr update: on every packet-ending transfer (in_last = 1), in either mode, rr_ptr = (source channel + 1) mod NUM_CH. Wrap: channel NUM_CH-1 ends → rr_ptr = 0. For non-power-of-2 NUM_CH, use an explicit compare, not bit truncation.
- Output stage:
  - On an input transfer, out_data/out_last/out_ch are loaded from the source channel and out_valid is set to 1.
  - If out_ready && out_valid with no new transfer, out_valid is cleared. Data fields hold their last value.
  - Latency: 1 cycle from input handshake to out_valid. Full throughput is 1 beat/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, all in_ready are 0 and no state changes occur.
- Simultaneous events: in the same cycle, output drain and a new load both happen; out_valid stays 1.
- Reset mid-packet: the lock is dropped and the pending output beat is discarded. The upstream producer must restart its packet.
- busy = (state == LOCKED), registered.

Decomposition:
- Package stream_mux_pkg:
  - mode_e enum {MODE_SELECT = 1'b0, MODE_RR = 1'b1}.
  - state_e enum {ST_IDLE, ST_LOCKED}.
- Sub-module rr_pick, purely combinational:
  - Parameter NUM_CH.
  - Inputs: req[NUM_CH], ptr[CH_W].
  - Outputs: found, idx[CH_W].
  - Implementation: rotate, priority-encode, un-rotate.
- The top level instantiates one rr_pick.

Test Plan:
- Reset: drive rst_n low mid-stream with in_valid = 4'b1111 → out_valid = 0, in_ready = 0, busy = 0 asynchronously. The first grant after release is channel 0 in RR mode.
- SELECT mode: sel = 2, ch2 sends 3-beat packet 0xA1, 0xA2, 0xA3 (last on the third). Change sel to 0 after beat 1. → Output is 0xA1, 0xA2, 0xA3, all with out_ch = 2; ch0 is ignored until out_last. busy is high for beats 2–3.
- RR fairness: all 4 channels valid with single-beat packets (data = 0x10 + ch), out_ready = 1 → out_ch sequence 0, 1, 2, 3, 0, 1…, one beat per cycle.
- RR wrap/skip: rr_ptr = 3, only ch1 valid → ch1 granted and rr_ptr becomes 2. Then ch3 ends a packet → rr_ptr = 0.
- Backpressure: out_ready = 0 for 3 cycles during a locked packet → out_data is held stable, in_ready = 0. Release → no beat lost or duplicated; the total beat count equals the input count.
- Invalid select: NUM_CH = 3 instance, sel = 3 with all in_valid set → no transfer, in_ready = 0, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types for the stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      MODE_SELECT = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/stream_mux_if.sv
// Multi-producer / single-consumer valid-ready bundle for stream_mux.
interface stream_mux_if
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_last;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic                    out_last;
   logic [CH_W-1:0]         out_ch;
   logic                    out_ready;

   // Producer/consumer side (testbench or surrounding fabric).
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_ch
   );

   // Multiplexer side.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_ch
   );
endinterface

// File: rtl/stream_mux_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic              found,
   output logic [CH_W-1:0]   idx
);

   // Rotation, priority encode and un-rotation folded into one scan:
   // position j of the rotated vector is channel (ptr + j) mod NUM_CH.
   always_comb begin
      int unsigned k;
      found = 1'b0;
      idx   = '0;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
         k = j + 32'(ptr);
         if (k >= NUM_CH) k = k - NUM_CH;
         if (!found && req[k]) begin
            found = 1'b1;
            idx   = CH_W'(k);
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N-channel packet-aware stream multiplexer with registered output stage.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mode,
   input  logic [CH_W-1:0] sel,
   output logic            busy,
   stream_mux_if.slave     bus
);

   state_e          state;
   logic [CH_W-1:0] grant;
   logic [CH_W-1:0] rr_ptr;

   logic            load;
   logic            rr_found;
   logic [CH_W-1:0] rr_idx;
   logic            sel_found;
   logic            cand_found;
   logic [CH_W-1:0] cand_idx;
   logic            active_found;
   logic [CH_W-1:0] active_idx;
   logic            src_valid;
   logic            src_last;
   logic [WIDTH-1:0] src_data;
   logic            xfer;

   rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
      .req   (bus.in_valid),
      .ptr   (rr_ptr),
      .found (rr_found),
      .idx   (rr_idx)
   );

   assign load = !bus.out_valid || bus.out_ready;

   // Candidate in IDLE (select or round-robin); the grant owns the mux while LOCKED.
   always_comb begin
      sel_found = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (sel == CH_W'(i) && bus.in_valid[i]) sel_found = 1'b1;
      end
      if (mode == MODE_RR) begin
         cand_found = rr_found;
         cand_idx   = rr_idx;
      end else begin
         cand_found = sel_found;
         cand_idx   = sel;
      end
      if (state == ST_LOCKED) begin
         active_found = 1'b1;
         active_idx   = grant;
      end else begin
         active_found = cand_found;
         active_idx   = cand_idx;
      end
   end

   // Source beat mux and one-hot ready towards the active channel.
   always_comb begin
      src_valid    = 1'b0;
      src_last     = 1'b0;
      src_data     = '0;
      bus.in_ready = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (active_idx == CH_W'(i)) begin
            src_valid       = bus.in_valid[i];
            src_last        = bus.in_last[i];
            src_data        = bus.in_data[i*WIDTH +: WIDTH];
            bus.in_ready[i] = rst_n && load && active_found;
         end
      end
      xfer = load && active_found && src_valid;
   end

   // Packet lock and round-robin pointer; the pointer wraps by compare so odd NUM_CH works.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else if (xfer) begin
         if (src_last) begin
            state  <= ST_IDLE;
            rr_ptr <= (active_idx == CH_W'(NUM_CH - 1)) ? '0 : active_idx + 1'b1;
         end else begin
            state <= ST_LOCKED;
            grant <= active_idx;
         end
      end
   end

   // Output register: load on transfer, otherwise drain when the consumer accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_ch    <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= src_data;
         bus.out_last  <= src_last;
         bus.out_ch    <= active_idx;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   assign busy = (state == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (4-channel and 3-channel instances).
module tb_stream_mux;

   logic       clk;
   logic       rst_n;
   logic       mode4, mode3;
   logic [1:0] sel4, sel3;
   logic       busy4, busy3;
   int         checks;
   int         errors;

   stream_mux_if #(.NUM_CH(4), .WIDTH(8)) m4 ();
   stream_mux_if #(.NUM_CH(3), .WIDTH(8)) m3 ();

   stream_mux #(.NUM_CH(4), .WIDTH(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4), .busy(busy4), .bus(m4)
   );

   stream_mux #(.NUM_CH(3), .WIDTH(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .busy(busy3), .bus(m3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      mode4        = 1'b0; sel4 = '0;
      mode3        = 1'b0; sel3 = '0;
      m4.in_valid  = '0; m4.in_data = '0; m4.in_last = '0; m4.out_ready = 1'b0;
      m3.in_valid  = '0; m3.in_data = '0; m3.in_last = '0; m3.out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      m4.in_valid = 4'hF;
      #3;
      checks++; if (m4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h exp 0", m4.out_valid); end
      checks++; if (m4.in_ready !== 4'h0) begin errors++; $display("FAIL rst_in_ready got %0h exp 0", m4.in_ready); end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy4); end
      checks++; if (m4.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %0h exp 0", m4.out_data); end
      tick();
      rst_n = 1'b1;
      mode4 = 1'b1; m4.out_ready = 1'b1; m4.in_last = 4'h0;
      m4.in_data = {8'h53, 8'h52, 8'h51, 8'h50};
      tick();
      checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %0h exp 1", busy4); end
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (m4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %0h exp 0", m4.out_valid); end
      checks++; if (m4.in_ready !== 4'h0) begin errors++; $display("FAIL rst_mid_in_ready got %0h exp 0", m4.in_ready); end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0h exp 0", busy4); end
      rst_n = 1'b1;
      m4.in_last = 4'hF;
      #1;
      checks++; if (m4.in_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_ready got %0h exp 1", m4.in_ready); end
      tick();
      checks++; if (m4.out_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid got %0h exp 1", m4.out_valid); end
      checks++; if (m4.out_ch !== 2'd0) begin errors++; $display("FAIL rst_first_ch got %0h exp 0", m4.out_ch); end
      checks++; if (m4.out_data !== 8'h50) begin errors++; $display("FAIL rst_first_data got %0h exp 50", m4.out_data); end
   endtask

   task automatic test_select();
      do_reset();
      mode4 = 1'b0; sel4 = 2'd2; m4.out_ready = 1'b1;
      m4.in_valid = 4'b0101; m4.in_last = 4'b0000;
      m4.in_data  = {8'h00, 8'hA1, 8'h00, 8'h0F};
      #1;
      checks++; if (m4.in_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready0 got %0h exp 4", m4.in_ready); end
      tick();
      sel4 = 2'd0;
      m4.in_data = {8'h00, 8'hA2, 8'h00, 8'h0F};
      #1;
      checks++; if (m4.out_data !== 8'hA1) begin errors++; $display("FAIL sel_data1 got %0h exp a1", m4.out_data); end
      checks++; if (m4.out_ch !== 2'd2) begin errors++; $display("FAIL sel_ch1 got %0h exp 2", m4.out_ch); end
      checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL sel_busy1 got %0h exp 1", busy4); end
      checks++; if (m4.in_ready !== 4'b0100) begin errors++; $display("FAIL sel_locked_ready got %0h exp 4", m4.in_ready); end
      tick();
      m4.in_data = {8'h00, 8'hA3, 8'h00, 8'h0F};
      m4.in_last = 4'b0100;
      #1;
      checks++; if (m4.out_data !== 8'hA2) begin errors++; $display("FAIL sel_data2 got %0h exp a2", m4.out_data); end
      checks++; if (m4.out_ch !== 2'd2) begin errors++; $display("FAIL sel_ch2 got %0h exp 2", m4.out_ch); end
      checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL sel_busy2 got %0h exp 1", busy4); end
      tick();
      m4.in_valid = 4'b0001; m4.in_last = 4'b0000;
      #1;
      checks++; if (m4.out_data !== 8'hA3) begin errors++; $display("FAIL sel_data3 got %0h exp a3", m4.out_data); end
      checks++; if (m4.out_last !== 1'b1) begin errors++; $display("FAIL sel_last3 got %0h exp 1", m4.out_last); end
      checks++; if (m4.out_ch !== 2'd2) begin errors++; $display("FAIL sel_ch3 got %0h exp 2", m4.out_ch); end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL sel_busy3 got %0h exp 0", busy4); end
      checks++; if (m4.in_ready !== 4'b0001) begin errors++; $display("FAIL sel_ready_ch0 got %0h exp 1", m4.in_ready); end
      tick();
      m4.in_valid = 4'b0000;
      checks++; if (m4.out_ch !== 2'd0) begin errors++; $display("FAIL sel_ch0_out got %0h exp 0", m4.out_ch); end
      checks++; if (m4.out_data !== 8'h0F) begin errors++; $display("FAIL sel_ch0_data got %0h exp f", m4.out_data); end
   endtask

   task automatic test_rr_fairness();
      do_reset();
      mode4 = 1'b1; m4.out_ready = 1'b1;
      m4.in_valid = 4'hF; m4.in_last = 4'hF;
      m4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++; if (m4.out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid_%0d got %0h exp 1", k, m4.out_valid); end
         checks++; if (m4.out_ch !== 2'(k % 4)) begin errors++; $display("FAIL rr_ch_%0d got %0h exp %0h", k, m4.out_ch, k % 4); end
         checks++; if (m4.out_data !== 8'(8'h10 + k % 4)) begin errors++; $display("FAIL rr_data_%0d got %0h exp %0h", k, m4.out_data, 8'h10 + k % 4); end
      end
   endtask

   task automatic test_rr_wrap();
      do_reset();
      mode4 = 1'b1; m4.out_ready = 1'b1; m4.in_last = 4'hF;
      m4.in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
      m4.in_valid = 4'b0100;
      tick();
      m4.in_valid = 4'b0010;
      #1;
      checks++; if (m4.in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_skip_ready got %0h exp 2", m4.in_ready); end
      tick();
      checks++; if (m4.out_ch !== 2'd1) begin errors++; $display("FAIL wrap_ch1 got %0h exp 1", m4.out_ch); end
      m4.in_valid = 4'hF;
      #1;
      checks++; if (m4.in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2_ready got %0h exp 4", m4.in_ready); end
      m4.in_valid = 4'b1000;
      #1;
      checks++; if (m4.in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ch3_ready got %0h exp 8", m4.in_ready); end
      tick();
      checks++; if (m4.out_data !== 8'h23) begin errors++; $display("FAIL wrap_ch3_data got %0h exp 23", m4.out_data); end
      m4.in_valid = 4'hF;
      #1;
      checks++; if (m4.in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ptr0_ready got %0h exp 1", m4.in_ready); end
   endtask

   task automatic test_backpressure();
      int sent;
      int rx;
      do_reset();
      sent = 0; rx = 0;
      mode4 = 1'b0; sel4 = 2'd1;
      for (int c = 0; c < 40 && rx < 6; c++) begin
         m4.out_ready = !(c >= 2 && c <= 4);
         m4.in_valid  = (sent < 6) ? 4'b0010 : 4'b0000;
         m4.in_data   = {8'h00, 8'h00, 8'(8'h31 + sent), 8'h00};
         m4.in_last   = (sent == 5) ? 4'b0010 : 4'b0000;
         #1;
         if (m4.out_valid) begin
            checks++; if (m4.out_data !== 8'(8'h31 + rx)) begin errors++; $display("FAIL bp_order_c%0d got %0h exp %0h", c, m4.out_data, 8'h31 + rx); end
         end
         if (m4.out_valid && !m4.out_ready) begin
            checks++; if (m4.in_ready !== 4'h0) begin errors++; $display("FAIL bp_ready_c%0d got %0h exp 0", c, m4.in_ready); end
            checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL bp_busy_c%0d got %0h exp 1", c, busy4); end
         end
         if (m4.in_valid[1] && m4.in_ready[1]) sent++;
         if (m4.out_valid && m4.out_ready) rx++;
         tick();
      end
      m4.in_valid = 4'h0;
      checks++; if (rx !== 6) begin errors++; $display("FAIL bp_rx_count got %0d exp 6", rx); end
      checks++; if (sent !== 6) begin errors++; $display("FAIL bp_tx_count got %0d exp 6", sent); end
      checks++; if (m4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0h exp 0", m4.out_valid); end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL bp_end_busy got %0h exp 0", busy4); end
   endtask

   task automatic test_invalid_sel();
      do_reset();
      mode3 = 1'b0; sel3 = 2'd3; m3.out_ready = 1'b1;
      m3.in_valid = 3'b111; m3.in_last = 3'b111;
      m3.in_data  = {8'hC2, 8'hC1, 8'hC0};
      #1;
      checks++; if (m3.in_ready !== 3'b000) begin errors++; $display("FAIL inv_ready0 got %0h exp 0", m3.in_ready); end
      tick();
      checks++; if (m3.out_valid !== 1'b0) begin errors++; $display("FAIL inv_valid1 got %0h exp 0", m3.out_valid); end
      checks++; if (m3.in_ready !== 3'b000) begin errors++; $display("FAIL inv_ready1 got %0h exp 0", m3.in_ready); end
      tick();
      checks++; if (m3.out_valid !== 1'b0) begin errors++; $display("FAIL inv_valid2 got %0h exp 0", m3.out_valid); end
      sel3 = 2'd2;
      #1;
      checks++; if (m3.in_ready !== 3'b100) begin errors++; $display("FAIL inv_sel2_ready got %0h exp 4", m3.in_ready); end
      tick();
      checks++; if (m3.out_ch !== 2'd2) begin errors++; $display("FAIL inv_sel2_ch got %0h exp 2", m3.out_ch); end
      checks++; if (m3.out_data !== 8'hC2) begin errors++; $display("FAIL inv_sel2_data got %0h exp c2", m3.out_data); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      mode4  = 1'b0; sel4 = '0;
      mode3  = 1'b0; sel3 = '0;
      m4.in_valid = '0; m4.in_data = '0; m4.in_last = '0; m4.out_ready = 1'b0;
      m3.in_valid = '0; m3.in_data = '0; m3.in_last = '0; m3.out_ready = 1'b0;
      test_reset();
      test_select();
      test_rr_fairness();
      test_rr_wrap();
      test_backpressure();
      test_invalid_sel();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
